// File: rtl/nearest_vertex_search.sv
// Nearest-vertex search controller: streams vertices from a synchronous memory through
// the squared-distance engine, one outstanding vertex at a time, tracking the minimum.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start_in; results from last search held
// S_FETCH  | mem_addr_out = index held MEM_LATENCY cycles, data captured last cycle
// S_ISSUE  | DIM cycles presenting vertex/query to the engine
// S_WAIT   | waiting for dist_valid_in under a TIMEOUT-cycle watchdog
// S_UPDATE | compare latched result with best, advance index
// S_DONE   | one-cycle completion pulse
module nearest_vertex_search #(
    parameter int DIM         = 2,
    parameter int ADDR_WIDTH  = 6,
    parameter int MEM_LATENCY = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic [DIM*32-1:0]       query_pos_in,
    input  logic [ADDR_WIDTH:0]     num_vertices_in,
    output logic [ADDR_WIDTH-1:0]   mem_addr_out,
    input  logic [DIM*32-1:0]       mem_data_in,
    output logic [DIM-1:0]          dist_valid_out,
    output logic [DIM*32-1:0]       dist_vertex_out,
    output logic [DIM*32-1:0]       dist_query_out,
    input  logic [31:0]             dist_sq_in,
    input  logic                    dist_valid_in,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    found_out,
    output logic                    error_out,
    output logic [ADDR_WIDTH-1:0]   best_index_out,
    output logic [31:0]             best_dist_sq_out
);

    localparam int CNT_MAX = (TIMEOUT > MEM_LATENCY) ? ((TIMEOUT > DIM) ? TIMEOUT : DIM)
                                                     : ((MEM_LATENCY > DIM) ? MEM_LATENCY : DIM);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_WIDTH:0] N_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_UPDATE, S_DONE
    } state_t;

    state_t                 state_q, next_state;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDR_WIDTH-1:0]  index_q;
    logic [ADDR_WIDTH:0]    n_q;
    logic [DIM*32-1:0]      vertex_q;
    logic [DIM*32-1:0]      query_q;
    logic [31:0]            result_q;
    logic                   cnt_zero;
    logic                   last_vertex;

    assign cnt_zero    = (cnt_q == '0);
    assign last_vertex = ({1'b0, index_q} == (n_q - 1'b1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= S_IDLE;
        else         state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE:   if (start_in) next_state = (num_vertices_in == '0) ? S_DONE : S_FETCH;
            S_FETCH:  if (cnt_zero) next_state = S_ISSUE;
            S_ISSUE:  if (cnt_zero) next_state = S_WAIT;
            S_WAIT: begin
                if (dist_valid_in) next_state = S_UPDATE;
                else if (cnt_zero) next_state = S_DONE;
            end
            S_UPDATE: next_state = last_vertex ? S_DONE : S_FETCH;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy_out       = (state_q != S_IDLE);
        done_out       = (state_q == S_DONE);
        dist_valid_out = {DIM{state_q == S_ISSUE}};
    end

    assign mem_addr_out    = index_q;
    assign dist_vertex_out = vertex_q;
    assign dist_query_out  = query_q;

    // One down-counter is shared by FETCH, ISSUE and the WAIT watchdog; it reloads on entry.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else if (state_q != next_state) begin
            case (next_state)
                S_FETCH: cnt_q <= CNT_W'(MEM_LATENCY - 1);
                S_ISSUE: cnt_q <= CNT_W'(DIM - 1);
                S_WAIT:  cnt_q <= CNT_W'(TIMEOUT - 1);
                default: cnt_q <= '0;
            endcase
        end else if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            index_q          <= '0;
            n_q              <= '0;
            vertex_q         <= '0;
            query_q          <= '0;
            result_q         <= '0;
            found_out        <= 1'b0;
            error_out        <= 1'b0;
            best_index_out   <= '0;
            best_dist_sq_out <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start_in) begin
                    query_q          <= query_pos_in;
                    n_q              <= (num_vertices_in > N_MAX) ? N_MAX : num_vertices_in;
                    index_q          <= '0;
                    found_out        <= 1'b0;
                    error_out        <= 1'b0;
                    best_index_out   <= '0;
                    best_dist_sq_out <= 32'hFFFF_FFFF;
                end
                S_FETCH: if (cnt_zero) vertex_q <= mem_data_in;
                S_WAIT: begin
                    if (dist_valid_in) result_q <= dist_sq_in;
                    else if (cnt_zero) error_out <= 1'b1;
                end
                S_UPDATE: begin
                    // Strict compare: equal distances keep the earlier index.
                    if (!found_out || (result_q < best_dist_sq_out)) begin
                        best_dist_sq_out <= result_q;
                        best_index_out   <= index_q;
                        found_out        <= 1'b1;
                    end
                    if (!last_vertex) index_q <= index_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/nearest_vertex_search.md
# nearest_vertex_search

Search controller that drives the squared-distance engine from the initiator side. On `start_in` it captures a query point, reads vertices one at a time from a synchronous vertex memory, and presents each vertex with the query to the distance engine. It collects each `distance_sq` result and keeps the running minimum, then reports the index and squared distance of the nearest vertex. The block sits between the vertex BRAM and the distance engine in the nearest-neighbour datapath.

## Interface
- `DIM`, 2, number of coordinates per point
- `ADDR_WIDTH`, 6, vertex memory address width
- `MEM_LATENCY`, 2, cycles from address to valid `mem_data_in` (≥1)
- `TIMEOUT`, 255, maximum WAIT cycles before abort (≥1)

Ports:
- `clk_in` in 1: single clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `start_in` in 1: begin search; sampled only in IDLE.
- `query_pos_in` in [DIM] x 32: query coordinates, captured at start.
- `num_vertices_in` in ADDR_WIDTH+1: vertex count N, captured at start.
- `mem_addr_out` out ADDR_WIDTH: vertex memory address.
- `mem_data_in` in [DIM] x 32: vertex coordinates from memory.
- `dist_valid_out` out [DIM] x 1: per-dimension valid to the distance engine.
- `dist_vertex_out` out [DIM] x 32: vertex coordinates to the engine.
- `dist_query_out` out [DIM] x 32: query coordinates to the engine.
- `dist_sq_in` in 32: engine result.
- `dist_valid_in` in 1: engine result valid, one-cycle pulse.
- `busy_out` out 1: high from the first cycle after start through DONE.
- `done_out` out 1: one-cycle completion pulse.
- `found_out` out 1: at least one result was accepted.
- `error_out` out 1: search aborted by timeout.
- `best_index_out` out ADDR_WIDTH: index of the nearest vertex.
- `best_dist_sq_out` out 32: squared distance of the nearest vertex.

## Operation
- Reset (async assert, sync release): state IDLE. All outputs 0, including `best_dist_sq_out` and every `dist_valid_out` bit. Internal counters 0.
- IDLE, `start_in`=1:
  - capture the query and N; set `best_dist_sq_out`=32'hFFFF_FFFF, `found_out`=0, `error_out`=0, vertex index=0.
  - Go to FETCH, or to DONE if N=0.
- FETCH:
  - `mem_addr_out`=index, held for MEM_LATENCY cycles.
  - `mem_data_in` is registered into the vertex register on the last FETCH cycle.
  - Then go to ISSUE.
- ISSUE:
  - DIM cycles, all `dist_valid_out` bits=1.
  - `dist_vertex_out` and `dist_query_out` stay stable from the first ISSUE cycle until `dist_valid_in` is accepted.
  - `dist_valid_out`=0 in every other state.
  - Then go to WAIT.
- WAIT:
  - Wait for `dist_valid_in`=1; latch `dist_sq_in` and go to UPDATE.
  - A watchdog counts WAIT cycles. If TIMEOUT cycles pass with no result, set `error_out`=1 and go to DONE.
- UPDATE (1 cycle):
  - if `found_out`=0, or `dist_sq_in` < `best_dist_sq_out` (unsigned, strict), load the result into best and set `found_out`=1.
  - Ties keep the lower index.
  - If index = N−1 go to DONE; otherwise index+1 and go to FETCH.
- DONE (1 cycle): `done_out`=1, then IDLE.
- Results hold until the next start or reset.
- `dist_valid_in` outside WAIT is ignored.
- `start_in` outside IDLE is ignored.
- Only one vertex is outstanding at the engine at any time.
- Reset mid-search aborts immediately; no `done_out` pulse.
- N > 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH.

## Timing
- Per-vertex cost is MEM_LATENCY + DIM + L + 1 cycles.
  - L = number of WAIT cycles, counting the cycle in which `dist_valid_in` is sampled high.
- Cycle 1 is the first cycle after the start edge.
- `done_out` is high in cycle N·(MEM_LATENCY+DIM+L+1)+1.
  - For N=0: cycle 1.
  - For a timeout on vertex k (0-based): cycle k·(MEM_LATENCY+DIM+L+1) + MEM_LATENCY + DIM + TIMEOUT + 1.
- `busy_out` is 1 exactly while state ≠ IDLE.
- Outputs are registered; no combinational path from input to output.

## Test plan
- Setup: DIM=2, MEM_LATENCY=2, engine model with L=3, query (0,0), vertices (3,4),(1,1),(5,0), N=3.
  - Required: done in cycle 25, `best_index_out`=1, `best_dist_sq_out`=2, `found_out`=1, `error_out`=0.
- Tie: vertices (1,0),(0,1), N=2 -> `best_index_out`=0, `best_dist_sq_out`=1.
- N=0 -> `done_out` in cycle 1, `found_out`=0, `best_dist_sq_out`=FFFF_FFFF, no `dist_valid_out` activity.
- Engine silent, TIMEOUT=16, N=3:
  - Required: done in cycle 21, `error_out`=1, `found_out`=0.
  - `dist_valid_out` high exactly 2 cycles.
- Reset asserted during WAIT of vertex 1:
  - Required: all outputs 0 immediately and no `done_out`.
  - A new start afterwards completes normally with the scenario-1 results.
- `start_in` pulsed mid-search, plus a stray `dist_valid_in` in FETCH -> both ignored; results match scenario 1.
